// File: rtl/adder_4bit_2step_if.sv
// Operand/result bundle for the two-stage pipelined adder.
// The master drives operands and carry-in; the slave returns the registered sum and carry-out.
interface adder_4bit_2step_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] cin_a;
  logic [DATA_W-1:0] cin_b;
  logic              cin;
  logic [DATA_W-1:0] sum;
  logic              cout;

  modport master (output cin_a, cin_b, cin, input sum, cout);
  modport slave  (input cin_a, cin_b, cin, output sum, cout);
endinterface

// File: rtl/adder_4bit_2step.sv
// DATA_W-bit adder (DATA_W even) with the carry chain cut into two registered halves.
// Fixed 2-cycle latency, one result per clock; {cout, sum} = cin_a + cin_b + cin.
module adder_4bit_2step #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                srst,
  adder_4bit_2step_if.slave   bus
);
  localparam int HALF_W = DATA_W / 2;

  // Stage-1 state: low-half result, its carry, and the high operands skewed by one cycle.
  logic [HALF_W-1:0] low_sum_r;
  logic              c1_r;
  logic [HALF_W-1:0] a_hi_r;
  logic [HALF_W-1:0] b_hi_r;

  // Stage-2 state: the full registered result.
  logic [HALF_W-1:0] sum_lo_r;
  logic [HALF_W-1:0] sum_hi_r;
  logic              cout_r;

  logic [HALF_W:0] low_add;
  logic [HALF_W:0] high_add;

  // Each add is one bit wider than its half so the carry-out falls out as the MSB.
  always_comb begin
    low_add  = {1'b0, bus.cin_a[HALF_W-1:0]} + {1'b0, bus.cin_b[HALF_W-1:0]}
             + {{HALF_W{1'b0}}, bus.cin};
    high_add = {1'b0, a_hi_r} + {1'b0, b_hi_r} + {{HALF_W{1'b0}}, c1_r};
  end

  // NOTE: every pipeline register is plain flop state, so all of it is cleared on reset;
  // non-blocking assignments let both stages shift on the same edge without racing.
  always_ff @(posedge clk) begin
    if (srst) begin
      low_sum_r <= '0;
      c1_r      <= 1'b0;
      a_hi_r    <= '0;
      b_hi_r    <= '0;
      sum_lo_r  <= '0;
      sum_hi_r  <= '0;
      cout_r    <= 1'b0;
    end else begin
      low_sum_r <= low_add[HALF_W-1:0];
      c1_r      <= low_add[HALF_W];
      a_hi_r    <= bus.cin_a[DATA_W-1:HALF_W];
      b_hi_r    <= bus.cin_b[DATA_W-1:HALF_W];
      sum_lo_r  <= low_sum_r;
      sum_hi_r  <= high_add[HALF_W-1:0];
      cout_r    <= high_add[HALF_W];
    end
  end

  assign bus.sum  = {sum_hi_r, sum_lo_r};
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_adder_4bit_2step.sv
// Directed, table-driven bench for adder_4bit_2step: vectors stream back-to-back and
// each result is compared one edge after the edge following its sampling edge.
module tb_adder_4bit_2step;
  logic clk  = 1'b0;
  logic srst = 1'b1;

  adder_4bit_2step_if #(.DATA_W(8)) bus ();

  adder_4bit_2step #(.DATA_W(8)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] exp;   // {cout, sum}
  } vec_t;

  vec_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [8:0] exp);
    checks++;
    if ({bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL %s: got sum=%02h cout=%0b, want sum=%02h cout=%0b",
               name, bus.sum, bus.cout, exp[7:0], exp[8]);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.cin_a = a;
    bus.cin_b = b;
    bus.cin   = c;
  endtask

  // One rising edge, then settle away from it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams q with no bubbles; the vector driven before edge k is visible after edge k+1.
  task automatic apply_queue(input string tag);
    for (int i = 0; i <= q.size(); i++) begin
      if (i < q.size()) drive(q[i].a, q[i].b, q[i].c);
      else              drive(8'h00, 8'h00, 1'b0);
      step();
      if (i >= 1) check($sformatf("%s[%0d]", tag, i - 1), q[i - 1].exp);
    end
  endtask

  initial begin
    // Reset with nonzero operands present: outputs must still read zero.
    drive(8'hAA, 8'h55, 1'b1);
    srst = 1'b1;
    step();
    check("reset_edge1", 9'h000);
    step();
    check("reset_edge2", 9'h000);
    srst = 1'b0;

    // Directed vectors with hand-computed {cout, sum}.
    q = {};
    q.push_back('{8'h00, 8'h0A, 1'b0, 9'h00A});
    q.push_back('{8'h0F, 8'h01, 1'b0, 9'h010});
    q.push_back('{8'h08, 8'h08, 1'b0, 9'h010});
    q.push_back('{8'hFF, 8'h01, 1'b0, 9'h100});
    q.push_back('{8'hFF, 8'hFF, 1'b1, 9'h1FF});
    q.push_back('{8'h00, 8'h00, 1'b1, 9'h001});
    q.push_back('{8'h80, 8'h80, 1'b0, 9'h100});
    q.push_back('{8'h7F, 8'h80, 1'b1, 9'h100});
    q.push_back('{8'hA5, 8'h5A, 1'b0, 9'h0FF});
    q.push_back('{8'h0F, 8'h00, 1'b1, 9'h010});
    apply_queue("directed");

    // Streaming ramp: n + (n+10) = 2n+10.
    q = {};
    for (int n = 0; n < 50; n++)
      q.push_back('{8'(n), 8'(n + 10), 1'b0, 9'(2 * n + 10)});
    apply_queue("ramp");

    // Alternating carries: a set with high-half carry next to one with low-half carry.
    q = {};
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) q.push_back('{8'hF0, 8'h10, 1'b0, 9'h100});
      else            q.push_back('{8'h0F, 8'h00, 1'b1, 9'h010});
    end
    apply_queue("alternate");

    // Reset in the middle of a ramp: in-flight results are dropped.
    for (int n = 0; n < 10; n++) begin
      drive(8'(n), 8'(n + 10), 1'b0);
      step();
      if (n >= 1) check($sformatf("midrst_pre[%0d]", n - 1), 9'(2 * (n - 1) + 10));
    end
    srst = 1'b1;
    drive(8'd10, 8'd20, 1'b0);
    step();
    check("midrst_reset_edge", 9'h000);
    srst = 1'b0;
    // First non-reset sampling edge; the output after it is a refill value, not checked.
    drive(8'd11, 8'd21, 1'b0);
    step();
    for (int n = 12; n < 20; n++) begin
      drive(8'(n), 8'(n + 10), 1'b0);
      step();
      check($sformatf("midrst_post[%0d]", n - 1), 9'(2 * (n - 1) + 10));
    end
    drive(8'h00, 8'h00, 1'b0);
    step();
    check("midrst_post[19]", 9'(2 * 19 + 10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
